nyq_fir_seq: RTL and testbench

- Tap sequencer for the Nyquist FIR filter. Sits directly upstream of the MAC stage.
- Accepts one input sample per valid/ready handshake and stores it in a circular delay line of NUM_TAPS samples. Holds a writable coefficient bank.
- For each accepted sample it drives the MAC with one clear cycle, then NUM_TAPS (sample, coefficient) pairs.
- Pulses Done_SO in the cycle the MAC accumulator holds the finished filter output.

---
 rtl/nyq_fir_seq.sv | 130 +++++++++++++
 tb/tb_nyq_fir_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nyq_fir_seq.sv
// Tap sequencer for the Nyquist FIR: accepts one sample per handshake into a
// circular delay line, then drives the MAC with one clear cycle and NUM_TAPS operand pairs.
module nyq_fir_seq #(
  parameter int DATA_WIDTH = 12,
  parameter int COEF_WIDTH = 12,
  parameter int NUM_TAPS   = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic                  SmpValid_SI,
  output logic                  SmpReady_SO,
  input  logic [DATA_WIDTH-1:0] Smp_DI,
  input  logic                  CoefWrEn_SI,
  input  logic [ADDR_WIDTH-1:0] CoefAddr_DI,
  input  logic [COEF_WIDTH-1:0] Coef_DI,
  output logic                  MacClr_SO,
  output logic                  MacWrEn_SO,
  output logic [DATA_WIDTH-1:0] MacIn0_DO,
  output logic [COEF_WIDTH-1:0] MacIn1_DO,
  output logic                  Busy_SO,
  output logic                  Done_SO
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_ACC   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_TAP = ADDR_WIDTH'(NUM_TAPS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] k_q, k_d;
  logic [ADDR_WIDTH-1:0] wp_q, wp_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] x_buf_q [NUM_TAPS];
  logic [COEF_WIDTH-1:0] h_q     [NUM_TAPS];

  logic                  accept;
  logic                  coef_we;
  logic [ADDR_WIDTH-1:0] rd_idx;

  // Handshake: a sample is consumed on a rising edge where SmpValid_SI and
  // SmpReady_SO are both high; SmpReady_SO is high only in IDLE.
  assign accept  = (state_q == S_IDLE) && SmpValid_SI;
  // Coefficient writes only in IDLE keep h stable across an accumulation.
  assign coef_we = (state_q == S_IDLE) && CoefWrEn_SI;
  // Power-of-two length, so the subtraction wraps modulo NUM_TAPS for free.
  assign rd_idx  = base_q - k_q;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      wp_q    <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wp_q    <= wp_d;
      base_q  <= base_d;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        x_buf_q[i] <= '0;
        h_q[i]     <= '0;
      end
    end else begin
      if (accept) x_buf_q[wp_q] <= Smp_DI;
      if (coef_we) h_q[CoefAddr_DI] <= Coef_DI;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wp_d    = wp_q;
    base_d  = base_q;
    case (state_q)
      S_IDLE: begin
        if (SmpValid_SI) begin
          wp_d    = wp_q + ONE;
          base_d  = wp_q;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        k_d     = '0;
        state_d = S_ACC;
      end
      S_ACC: begin
        k_d = k_q + ONE;
        if (k_q == LAST_TAP) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    SmpReady_SO = 1'b0;
    MacClr_SO   = 1'b0;
    MacWrEn_SO  = 1'b0;
    MacIn0_DO   = '0;
    MacIn1_DO   = '0;
    Busy_SO     = (state_q != S_IDLE);
    Done_SO     = 1'b0;
    case (state_q)
      S_IDLE:  SmpReady_SO = 1'b1;
      S_CLEAR: begin
        MacClr_SO  = 1'b1;
        MacWrEn_SO = 1'b1;
      end
      S_ACC: begin
        MacWrEn_SO = 1'b1;
        MacIn0_DO  = x_buf_q[rd_idx];
        MacIn1_DO  = h_q[k_q];
      end
      S_DONE:  Done_SO = 1'b1;
      default: SmpReady_SO = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_nyq_fir_seq.sv
// Directed bench for nyq_fir_seq: a behavioural MAC accumulates the DUT operands and
// each Done result is checked against a convolution scoreboard and against known values.
module tb_nyq_fir_seq;

  localparam int DW = 12;
  localparam int CW = 12;
  localparam int NT = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          smp_valid = 1'b0;
  logic          smp_ready;
  logic [DW-1:0] smp = '0;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [CW-1:0] coef = '0;
  logic          mac_clr, mac_wr_en, busy, done;
  logic [DW-1:0] mac_in0;
  logic [CW-1:0] mac_in1;

  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            acc_cyc = -100;
  int            prev_acc = -100;
  bit            cont = 1'b0;
  logic [31:0]   mac_acc = '0;
  logic [31:0]   exp_q[$];
  logic [31:0]   got_q[$];
  logic [DW-1:0] ref_x [NT];
  logic [CW-1:0] ref_h [NT];
  logic [AW-1:0] ref_wp;
  logic [DW-1:0] snap_x [NT];
  logic [CW-1:0] snap_h [NT];

  nyq_fir_seq #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .NUM_TAPS(NT), .ADDR_WIDTH(AW)) dut (
    .Clk_CI(clk), .Rst_RI(rst),
    .SmpValid_SI(smp_valid), .SmpReady_SO(smp_ready), .Smp_DI(smp),
    .CoefWrEn_SI(coef_we), .CoefAddr_DI(coef_addr), .Coef_DI(coef),
    .MacClr_SO(mac_clr), .MacWrEn_SO(mac_wr_en),
    .MacIn0_DO(mac_in0), .MacIn1_DO(mac_in1),
    .Busy_SO(busy), .Done_SO(done)
  );

  // Clock, cycle counter and behavioural MAC
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mac_wr_en) begin
      if (mac_clr) mac_acc <= '0;
      else         mac_acc <= mac_acc + 32'(mac_in0) * 32'(mac_in1);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: operand stream, clear/done timing and scoreboard pops
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        got_q.push_back(mac_acc);
        chk("done_latency", 32'(cyc - acc_cyc), 32'd18);
        if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else                   chk("done_result", mac_acc, exp_q.pop_front());
      end
      if (mac_clr) chk("clr_latency", 32'(cyc - acc_cyc), 32'd1);
      if (mac_wr_en && !mac_clr) begin
        automatic int tap = cyc - acc_cyc - 2;
        chk("acc_window", 32'(tap >= 0 && tap < NT), 32'd1);
        if (tap >= 0 && tap < NT) begin
          chk("tap_in0", 32'(mac_in0), 32'(snap_x[tap]));
          chk("tap_in1", 32'(mac_in1), 32'(snap_h[tap]));
        end
      end else begin
        chk("idle_operands", {8'd0, mac_in0, mac_in1}, 32'd0);
      end
    end
  end

  // Driver tasks (called at a negedge, return at a negedge)
  task automatic clear_model();
    for (int i = 0; i < NT; i++) begin
      ref_x[i] = '0; ref_h[i] = '0; snap_x[i] = '0; snap_h[i] = '0;
    end
    ref_wp = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic coef_write(input int k, input int v, input bit honoured);
    coef_we = 1'b1; coef_addr = AW'(k); coef = CW'(v);
    if (honoured) ref_h[k] = CW'(v);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic send_sample(input int s, input bit cw = 1'b0, input int ck = 0, input int cv = 0);
    int n;
    logic [31:0] y;
    logic [AW-1:0] idx;
    n = 0;
    smp_valid = 1'b1;
    while (!smp_ready && n < 60) begin
      smp = DW'($urandom_range(4095));
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 60), 32'd1);
    smp = DW'(s);
    if (cw) begin
      coef_we = 1'b1; coef_addr = AW'(ck); coef = CW'(cv);
      ref_h[ck] = CW'(cv);
    end
    ref_x[ref_wp] = DW'(s);
    y = '0;
    for (int k = 0; k < NT; k++) begin
      idx = ref_wp - AW'(k);
      snap_x[k] = ref_x[idx];
      snap_h[k] = ref_h[k];
      y = y + 32'(snap_x[k]) * 32'(snap_h[k]);
    end
    ref_wp = ref_wp + AW'(1);
    if (cont && prev_acc >= 0) chk("accept_interval", 32'(cyc - prev_acc), 32'd19);
    prev_acc = cyc;
    acc_cyc = cyc;
    exp_q.push_back(y);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    smp_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    clear_model();
    repeat (3) @(negedge clk);
    do_reset();
    chk("rst_ready", 32'(smp_ready), 32'd1);
    chk("rst_clr", 32'(mac_clr), 32'd0);
    chk("rst_wren", 32'(mac_wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_operands", {8'd0, mac_in0, mac_in1}, 32'd0);

    // Impulse through h[k]=k+1
    for (int k = 0; k < NT; k++) coef_write(k, k + 1, 1'b1);
    got_q.delete();
    send_sample(1);
    for (int i = 0; i < 15; i++) send_sample(0);
    wait_drain();
    chk("impulse_count", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < got_q.size(); i++) chk("impulse_resp", got_q[i], 32'(i + 1));

    // Valid held high: back-to-back accepts, junk offered while not ready
    cont = 1'b1;
    prev_acc = -100;
    send_sample(5);
    send_sample(6);
    send_sample(7);
    send_sample(8);
    cont = 1'b0;
    wait_drain();

    // All-ones taps across delay-line wrap
    do_reset();
    for (int k = 0; k < NT; k++) coef_write(k, 1, 1'b1);
    got_q.delete();
    for (int s = 1; s <= 20; s++) send_sample(s);
    wait_drain();
    chk("ones_count", 32'(got_q.size()), 32'd20);
    if (got_q.size() == 20) begin
      chk("ones_2nd", got_q[1], 32'd3);
      chk("ones_3rd", got_q[2], 32'd6);
      chk("ones_16th", got_q[15], 32'd136);
      chk("ones_17th", got_q[16], 32'd152);
      chk("ones_20th", got_q[19], 32'd200);
    end

    // Coefficient write during ACC is dropped; the same write in IDLE is kept
    do_reset();
    coef_write(0, 2, 1'b1);
    got_q.delete();
    send_sample(10);
    smp_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_in_acc", 32'(busy), 32'd1);
    coef_write(0, 7, 1'b0);
    wait_drain();
    send_sample(3);
    wait_drain();
    chk("drop_write", got_q[got_q.size() - 1], 32'd6);
    coef_write(0, 7, 1'b1);
    send_sample(1);
    wait_drain();
    chk("idle_write", got_q[got_q.size() - 1], 32'd7);

    // Reset at ACC k=5 aborts the sequence
    got_q.delete();
    send_sample(9);
    smp_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_reset_wren", 32'(mac_wr_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_wren", 32'(mac_wr_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(smp_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    clear_model();
    repeat (30) @(negedge clk);
    chk("abort_no_done", 32'(got_q.size()), 32'd0);
    coef_write(0, 4, 1'b1);
    send_sample(3);
    wait_drain();
    chk("after_reset", got_q[got_q.size() - 1], 32'd12);

    // Coefficient write and sample accept in the same IDLE cycle
    send_sample(2, 1'b1, 0, 5);
    wait_drain();
    chk("same_cycle", got_q[got_q.size() - 1], 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
